// File: rtl/muldiv_if.sv
// EX-stage handshake between the pipeline and the multiply/divide scheduler.
// The pipeline side drives the operation and operands; the scheduler returns stall, done and {HI,LO}.
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic                  op_valid;
  logic [5:0]            alu_control;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic [2*DATA_W-1:0]   hilo;
  logic                  flush;
  logic                  pipe_stall;
  logic                  stall;
  logic                  done;
  logic [2*DATA_W-1:0]   result;
  logic                  hilo_we;

  modport master (
    output op_valid, alu_control, src_a, src_b, hilo, flush, pipe_stall,
    input  stall, done, result, hilo_we
  );

  modport slave (
    input  op_valid, alu_control, src_a, src_b, hilo, flush, pipe_stall,
    output stall, done, result, hilo_we
  );
endinterface

// File: rtl/muldiv_scheduler.sv
// Sequencer for the shared EX-stage resource: 2-cycle multiply / MADD / MSUB and a
// 32-iteration radix-2 restoring divider. It stalls IF-EX while busy and commits {HI,LO} once.
module muldiv_scheduler #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     resetn,
  muldiv_if.slave  bus
);
  localparam logic [5:0] ALU_SIGNED_MULT   = 6'h18;
  localparam logic [5:0] ALU_UNSIGNED_MULT = 6'h19;
  localparam logic [5:0] ALU_SIGNED_DIV    = 6'h1A;
  localparam logic [5:0] ALU_UNSIGNED_DIV  = 6'h1B;
  localparam logic [5:0] ALU_MADD_MULT     = 6'h1C;
  localparam logic [5:0] ALU_MADDU_MULT    = 6'h1D;
  localparam logic [5:0] ALU_MSUB_MULT     = 6'h1E;
  localparam logic [5:0] ALU_MSUBU_MULT    = 6'h1F;
  localparam int         PW                = 2 * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [1:0] {K_MUL, K_MADD, K_MSUB} kind_t;

  state_t              state_reg;
  kind_t               kind_reg;
  logic                signed_reg;
  logic                neg_q_reg;
  logic                neg_r_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [PW-1:0]       hilo_reg;
  logic [PW-1:0]       result_reg;
  logic [DATA_W:0]     rem_reg;
  logic [5:0]          count_reg;

  logic                handled;
  logic                is_div;
  logic                op_signed;
  kind_t               kind;
  logic                start;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;

  always_comb begin
    handled   = 1'b1;
    is_div    = 1'b0;
    op_signed = 1'b0;
    kind      = K_MUL;
    case (bus.alu_control)
      ALU_SIGNED_MULT:   op_signed = 1'b1;
      ALU_UNSIGNED_MULT: op_signed = 1'b0;
      ALU_MADD_MULT:     begin op_signed = 1'b1; kind = K_MADD; end
      ALU_MADDU_MULT:    kind = K_MADD;
      ALU_MSUB_MULT:     begin op_signed = 1'b1; kind = K_MSUB; end
      ALU_MSUBU_MULT:    kind = K_MSUB;
      ALU_SIGNED_DIV:    begin op_signed = 1'b1; is_div = 1'b1; end
      ALU_UNSIGNED_DIV:  is_div = 1'b1;
      default:           handled = 1'b0;
    endcase
  end

  // Reset is folded in so that no stall request escapes while the block is held in reset.
  assign start = resetn & bus.op_valid & handled & (state_reg == S_IDLE) & ~bus.flush;
  assign mag_a = (op_signed & bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
  assign mag_b = (op_signed & bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;

  // Multiply path: 33-bit extended operands, product taken modulo 2^64.
  logic signed [DATA_W:0] ext_a;
  logic signed [DATA_W:0] ext_b;
  logic [PW-1:0]          product;
  logic [PW-1:0]          mac_result;

  assign ext_a   = {signed_reg & a_reg[DATA_W-1], a_reg};
  assign ext_b   = {signed_reg & b_reg[DATA_W-1], b_reg};
  assign product = PW'(ext_a) * PW'(ext_b);

  always_comb begin
    case (kind_reg)
      K_MADD:  mac_result = hilo_reg + product;
      K_MSUB:  mac_result = hilo_reg - product;
      default: mac_result = product;
    endcase
  end

  // Divide step: a_reg shifts the dividend out MSB-first and the quotient in LSB-first.
  logic [DATA_W+1:0]   diff;
  logic [DATA_W:0]     rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  assign diff     = {rem_reg, a_reg[DATA_W-1]} - {2'b00, b_reg};
  assign rem_next = diff[DATA_W+1] ? {rem_reg[DATA_W-1:0], a_reg[DATA_W-1]} : diff[DATA_W:0];
  assign quo_next = {a_reg[DATA_W-2:0], ~diff[DATA_W+1]};
  assign quo_fix  = neg_q_reg ? -quo_next : quo_next;
  assign rem_fix  = neg_r_reg ? -rem_next[DATA_W-1:0] : rem_next[DATA_W-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= S_IDLE;
      kind_reg   <= K_MUL;
      signed_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      hilo_reg   <= '0;
      result_reg <= '0;
      rem_reg    <= '0;
      count_reg  <= '0;
    end else if (bus.flush) begin
      state_reg  <= S_IDLE;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            kind_reg   <= kind;
            signed_reg <= op_signed;
            neg_q_reg  <= op_signed & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_r_reg  <= op_signed & bus.src_a[DATA_W-1];
            a_reg      <= is_div ? mag_a : bus.src_a;
            b_reg      <= is_div ? mag_b : bus.src_b;
            hilo_reg   <= bus.hilo;
            rem_reg    <= '0;
            count_reg  <= '0;
            if (!is_div) begin
              state_reg <= S_MUL;
            end else if (bus.src_b == '0) begin
              result_reg <= {bus.src_a, {DATA_W{1'b1}}};
              state_reg  <= S_DONE;
            end else begin
              state_reg <= S_DIV;
            end
          end
        end
        S_MUL: begin
          result_reg <= mac_result;
          state_reg  <= S_DONE;
        end
        S_DIV: begin
          a_reg     <= quo_next;
          rem_reg   <= rem_next;
          count_reg <= count_reg + 6'd1;
          if (count_reg == 6'd31) begin
            result_reg <= {rem_fix, quo_fix};
            state_reg  <= S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.pipe_stall) begin
            result_reg <= '0;
            state_reg  <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.stall   = ~bus.flush & (start | (state_reg == S_MUL) | (state_reg == S_DIV));
  assign bus.done    = (state_reg == S_DONE);
  assign bus.result  = result_reg;
  assign bus.hilo_we = (state_reg == S_DONE) & ~bus.pipe_stall & ~bus.flush;
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler: vector table of single ops plus flush, reset,
// unhandled-code and downstream-stall sequences.
module tb_muldiv_scheduler;
  localparam logic [5:0] ALU_SIGNED_MULT   = 6'h18;
  localparam logic [5:0] ALU_UNSIGNED_MULT = 6'h19;
  localparam logic [5:0] ALU_SIGNED_DIV    = 6'h1A;
  localparam logic [5:0] ALU_UNSIGNED_DIV  = 6'h1B;
  localparam logic [5:0] ALU_MADD_MULT     = 6'h1C;
  localparam logic [5:0] ALU_MADDU_MULT    = 6'h1D;
  localparam logic [5:0] ALU_MSUB_MULT     = 6'h1E;
  localparam logic [5:0] ALU_MSUBU_MULT    = 6'h1F;
  localparam logic [5:0] ALU_ADD           = 6'h20;

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  muldiv_if #(.DATA_W(32)) bus_if ();

  muldiv_scheduler #(.DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_outputs(input string name);
    check({name, ".flags"}, {61'd0, bus_if.stall, bus_if.done, bus_if.hilo_we}, 64'd0);
    check({name, ".result"}, bus_if.result, 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the op left DONE.
  task automatic run_op(input vec_t v);
    int st = 0;
    int we = 0;
    int dc = -1;
    logic we_at_done = 1'b0;
    logic [63:0] res = '0;
    bus_if.op_valid    = 1'b1;
    bus_if.alu_control = v.ctrl;
    bus_if.src_a       = v.a;
    bus_if.src_b       = v.b;
    bus_if.hilo        = v.hilo;
    for (int n = 0; n < 45; n++) begin
      #1;
      if (bus_if.stall) st++;
      if (bus_if.hilo_we) we++;
      if (bus_if.done && dc < 0) begin
        dc = n;
        res = bus_if.result;
        we_at_done = bus_if.hilo_we;
      end
      @(posedge clk); #1;
      if (n == 0) begin
        bus_if.src_a = $urandom;
        bus_if.src_b = $urandom;
        bus_if.hilo  = {$urandom, $urandom};
      end
      if (dc >= 0) break;
    end
    bus_if.op_valid = 1'b0;
    check({v.name, ".result"}, res, v.exp);
    check({v.name, ".stall_cycles"}, 64'(st), 64'(v.lat));
    check({v.name, ".done_cycle"}, 64'(dc), 64'(v.lat));
    check({v.name, ".hilo_we"}, {62'd0, we_at_done, 1'b0} | 64'(we), 64'd3);
    $display("op %-10s result=%h stall=%0d done@T+%0d we_pulses=%0d", v.name, res, st, dc, we);
  endtask

  vec_t vecs[12];

  initial begin
    int we;
    logic got;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{"mult",    ALU_SIGNED_MULT,   32'hFFFFFFFF, 32'h00000002, 64'h0, 64'hFFFFFFFF_FFFFFFFE, 2};
    vecs[1]  = '{"multu",   ALU_UNSIGNED_MULT, 32'hFFFFFFFF, 32'h00000002, 64'h0, 64'h00000001_FFFFFFFE, 2};
    vecs[2]  = '{"msub",    ALU_MSUB_MULT,     32'd3,        32'd5,        64'h0, 64'hFFFFFFFF_FFFFFFF1, 2};
    vecs[3]  = '{"maddu",   ALU_MADDU_MULT,    32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFFF, 64'h0, 2};
    vecs[4]  = '{"madd",    ALU_MADD_MULT,     32'hFFFFFFFE, 32'd3,        64'h10, 64'h0000000A, 2};
    vecs[5]  = '{"msubu",   ALU_MSUBU_MULT,    32'hFFFFFFFF, 32'd1,        64'h1_00000000, 64'h1, 2};
    vecs[6]  = '{"div_m7_2",ALU_SIGNED_DIV,    32'hFFFFFFF9, 32'd2,        64'h0, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[7]  = '{"div_7_m2",ALU_SIGNED_DIV,    32'd7,        32'hFFFFFFFE, 64'h0, 64'h00000001_FFFFFFFD, 33};
    vecs[8]  = '{"divu_100",ALU_UNSIGNED_DIV,  32'd100,      32'd7,        64'h0, 64'h00000002_0000000E, 33};
    vecs[9]  = '{"div_ovf", ALU_SIGNED_DIV,    32'h80000000, 32'hFFFFFFFF, 64'h0, 64'h00000000_80000000, 33};
    vecs[10] = '{"div_zero",ALU_SIGNED_DIV,    32'h12345678, 32'd0,        64'h0, 64'h12345678_FFFFFFFF, 1};
    vecs[11] = '{"divu_big",ALU_UNSIGNED_DIV,  32'hFFFFFFFF, 32'h10,       64'h0, 64'h0000000F_0FFFFFFF, 33};

    resetn = 1'b0;
    bus_if.op_valid = 1'b0; bus_if.alu_control = '0; bus_if.src_a = '0; bus_if.src_b = '0;
    bus_if.hilo = '0; bus_if.flush = 1'b0; bus_if.pipe_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 idle_outputs("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Unhandled code never starts anything.
    bus_if.op_valid = 1'b1; bus_if.alu_control = ALU_ADD; bus_if.src_a = 32'd9; bus_if.src_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1 idle_outputs($sformatf("unhandled%0d", i));
      @(posedge clk); #1;
    end
    bus_if.op_valid = 1'b0;
    $display("op unhandled held idle for 3 cycles");

    for (int i = 0; i < 12; i++) run_op(vecs[i]);

    // Flush at T+10 of a divide, then a multiply at T+11.
    we = 0;
    bus_if.op_valid = 1'b1; bus_if.alu_control = ALU_UNSIGNED_DIV;
    bus_if.src_a = 32'd100; bus_if.src_b = 32'd7;
    for (int n = 0; n <= 10; n++) begin
      if (n == 10) bus_if.flush = 1'b1;
      #1;
      if (bus_if.hilo_we) we++;
      if (n == 5)  check("flush.busy_stall", 64'(bus_if.stall), 64'd1);
      if (n == 10) check("flush.stall_forced_low", 64'(bus_if.stall), 64'd0);
      @(posedge clk); #1;
    end
    bus_if.flush = 1'b0; bus_if.op_valid = 1'b0;
    #1;
    check("flush.idle_flags", {62'd0, bus_if.stall, bus_if.done}, 64'd0);
    check("flush.no_hilo_we", 64'(we), 64'd0);
    $display("op flush_div aborted at T+10, hilo_we pulses=%0d", we);
    run_op(vecs[0]);

    // Reset while held in DONE by downstream stall.
    bus_if.pipe_stall = 1'b1;
    bus_if.op_valid = 1'b1; bus_if.alu_control = ALU_SIGNED_MULT;
    bus_if.src_a = 32'hFFFFFFFF; bus_if.src_b = 32'd2;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #1;
    check("rst.held_done", 64'(bus_if.done), 64'd1);
    check("rst.held_result", bus_if.result, 64'hFFFFFFFF_FFFFFFFE);
    resetn = 1'b0;
    #1 idle_outputs("rst.async");
    @(posedge clk); #1;
    resetn = 1'b1;
    bus_if.pipe_stall = 1'b0; bus_if.op_valid = 1'b0;
    $display("op reset_in_done cleared outputs");
    @(posedge clk); #1;

    // Downstream stall for 3 DONE cycles, then release and back-to-back divide.
    we = 0;
    bus_if.op_valid = 1'b1; bus_if.alu_control = ALU_UNSIGNED_DIV;
    bus_if.src_a = 32'hFFFFFFFF; bus_if.src_b = 32'h10;
    @(posedge clk); #1;
    bus_if.pipe_stall = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (bus_if.hilo_we) we++;
      if (bus_if.done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("pstall.reached_done", 64'(got), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("pstall.done%0d", k), 64'(bus_if.done), 64'd1);
      check($sformatf("pstall.result%0d", k), bus_if.result, 64'h0000000F_0FFFFFFF);
      check($sformatf("pstall.we_low%0d", k), 64'(bus_if.hilo_we), 64'd0);
      @(posedge clk); #2;
    end
    check("pstall.no_early_we", 64'(we), 64'd0);
    bus_if.pipe_stall = 1'b0;
    #1;
    check("pstall.release_we", {62'd0, bus_if.done, bus_if.hilo_we}, 64'd3);
    $display("op pstall_divu held 3 cycles, released with result=%h", bus_if.result);
    @(posedge clk); #1;
    run_op(vecs[8]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_scheduler.md
# muldiv_scheduler

Multi-cycle sequencer for the EX-stage multiply/divide resource. It accepts the decoded ALU control code and operands of the instruction currently in EX, and runs the shared multiplier (2 cycles) or the radix-2 restoring divider (32 iterations). It stalls the pipeline while busy and presents a 64-bit {HI,LO} result with a single-cycle HI/LO write strobe. It sits beside the ALU in EX and feeds the HI/LO register file.

## Interface
- DATA_W, 32, operand width; only 32 is supported.
- clk  in  1  pipeline clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid_i  in  1  EX holds a valid, non-flushed instruction.
- alu_control_i  in  6  ALU control code from aludefines.vh.
- src_a_i  in  32  rs operand (dividend / multiplicand).
- src_b_i  in  32  rt operand (divisor / multiplier).
- hilo_i  in  64  current {HI,LO}, forwarded; used by MADD/MSUB.
- flush_i  in  1  exception/flush of EX; aborts any operation.
- pipe_stall_i  in  1  downstream stall holding EX.
- stall_o  out  1  request to freeze IF–EX.
- done_o  out  1  result_o valid.
- result_o  out  64  {HI,LO}; for MUL the GPR value is result_o[31:0].
- hilo_we_o  out  1  commit result_o to HI/LO this cycle.

## Operation
- Handled codes:
  - ALU_SIGNED_MULT, ALU_UNSIGNED_MULT (MULT, MULTU, MUL).
  - ALU_MADD_MULT, ALU_MADDU_MULT, ALU_MSUB_MULT, ALU_MSUBU_MULT.
  - ALU_SIGNED_DIV, ALU_UNSIGNED_DIV.
  - Any other code: block stays IDLE and all outputs remain 0.
- start = op_valid_i & handled code & state==IDLE & !flush_i. On start, src_a_i, src_b_i, hilo_i and the op are captured.
- States: IDLE, MUL, DIV, DONE.
  - IDLE→MUL on a multiply-class start.
  - IDLE→DIV on a divide start with src_b_i≠0.
  - IDLE→DONE on a divide start with src_b_i==0.
  - MUL→DONE after 1 cycle.
  - DIV→DONE after the 32nd iteration.
  - DONE→IDLE when !pipe_stall_i; DONE holds while pipe_stall_i is high.
  - Any state→IDLE on flush_i.
- Multiply:
  - Operands are extended to 33 bits, sign- or zero-extended according to signedness.
  - The 64-bit product is truncated.
  - MADD/MADDU: result = hilo + product. MSUB/MSUBU: result = hilo − product. Both are modulo 2^64.
  - MULT/MULTU/MUL: result = product.
- Divide:
  - Works on magnitudes: |a| and |b| for signed, raw values for unsigned.
  - One quotient bit per cycle, MSB first, using a 33-bit partial remainder.
  - Signed correction on completion: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: no iterations are run and no sign correction is applied. HI = src_a_i, LO = 0xFFFFFFFF.
- HI/LO is written for every handled op, including MUL.

## Timing
- Reset values:
  - state=IDLE.
  - stall_o=0, done_o=0, hilo_we_o=0, result_o=0.
  - All internal operand, remainder and counter registers 0.
- stall_o is combinational: (start) | (state∈{MUL,DIV}). It is forced to 0 whenever flush_i=1.
- Latency, with start at cycle T:
  - Multiply: stall_o high in T and T+1; DONE in T+2.
  - Divide: stall_o high T..T+32 (33 cycles); DONE in T+33.
  - Divide by zero: stall_o high in T only; DONE in T+1.
- done_o is high whenever state==DONE. result_o is registered and stable throughout DONE.
- hilo_we_o = (state==DONE) & !pipe_stall_i & !flush_i. It pulses exactly once per completed op.
- The instruction in EX leaves on the DONE→IDLE edge. A new handled op may start in the very next cycle with no bubble.
- Flush or reset in MUL or DIV aborts the operation: no hilo_we_o, and IDLE on the next edge (reset: immediately).
- flush_i in the same cycle as a would-be start suppresses the start.
- Operand inputs changing after T have no effect.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002:
  - Signed: result_o = 0xFFFFFFFF_FFFFFFFE.
  - MULTU: result_o = 0x00000001_FFFFFFFE.
  - Both: stall_o high exactly 2 cycles, hilo_we_o one pulse at T+2.
- MSUB with hilo_i=0x0, a=3, b=5 → result_o = 0xFFFFFFFF_FFFFFFF1. MADDU with hilo_i=0xFFFFFFFF_FFFFFFFF, a=1, b=1 → result_o = 0 (wrap).
- DIV signed:
  - −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 7 / −2 → LO=0xFFFFFFFD, HI=1.
  - DIVU 100/7 → LO=14, HI=2.
  - Each: stall_o high 33 cycles, done_o at T+33.
- Divide by zero: DIV a=0x12345678, b=0 → done_o at T+1, HI=0x12345678, LO=0xFFFFFFFF, stall_o high 1 cycle.
- Flush at T+10 of a DIV → IDLE at T+11, stall_o low, no hilo_we_o. A MULT issued at T+11 completes normally. resetn low at T+5 of a MULT → all outputs 0 immediately.
- pipe_stall_i held 3 cycles in DONE → done_o and result_o held, hilo_we_o low. After release: exactly one hilo_we_o pulse, then back-to-back DIVU starts the next cycle.
